clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Multi-channel, runtime-programmable clock divider for board-level timing (LED blink rates, slow strobes, peripheral clock enables). It generates CHANNELS independent 50 % duty divided clocks plus one-cycle tick strobes from the single system clock. Divisors reload through a valid/ready configuration port, and changes apply glitch-free at the next half-period boundary.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16).
- DIV_W, 24: width of each divisor and counter, in bits.
- CLK_FREQ, 12_000_000: system clock frequency in Hz; used only to compute DEFAULT_DIV.
- DEFAULT_HZ, 1: output frequency each channel runs at after reset.
- DEFAULT_DIV, CLK_FREQ/(2*DEFAULT_HZ): reset divisor; must fit in DIV_W bits.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  CHANNELS  per-channel count enable.
- cfg_valid  input  1  divisor load request.
- cfg_ready  output  1  load can be accepted this cycle.
- cfg_chan  input  $clog2(CHANNELS) (minimum 1)  target channel index.
- cfg_div  input  DIV_W  new half-period divisor.
- clk_out  output  CHANNELS  divided clocks, registered.
- tick  output  CHANNELS  one-cycle strobe at every clk_out toggle, registered.
- sync  input  1  global realign; present only with CLKDIV_SYNC_EN.

## Operation
- Each channel has:
  - an active divisor `act[k]`,
  - a shadow divisor `shd[k]`,
  - a pending flag `pend[k]`,
  - a counter `cnt[k]`.
- Half-period equals `act[k]` cycles, so f_out = f_clk / (2·act[k]).
- On an edge with `en[k]=1` and `act[k]≠0`:
  - If `cnt[k]==act[k]-1`: `cnt[k]` becomes 0, `clk_out[k]` toggles, and `tick[k]` is 1 (this is the wrap).
  - Otherwise: `cnt[k]` increments and `tick[k]` is 0.
- With `en[k]=0`: counter and `clk_out[k]` hold, and `tick[k]` is 0.
- `act[k]==0` means the channel is stopped: counter holds at 0, `clk_out[k]` holds, and `tick[k]` is 0 regardless of `en`.
- Config handshake:
  - `cfg_ready = ~pend[cfg_chan] & ~rst`, combinational on `cfg_chan`.
  - On accept (`cfg_valid & cfg_ready`): `shd[cfg_chan] <= cfg_div` and `pend[cfg_chan] <= 1`.
  - `cfg_chan ≥ CHANNELS`: the request is accepted and discarded, with no state change.
- Shadow apply for channel k (`act <= shd`, `pend <= 0`) happens when either:
  - a wrap of channel k occurs and `pend[k]` was already set before this edge; the counter restarts at 0 under the new divisor; or
  - the channel is idle (`en[k]=0` or `act[k]==0`) with `pend[k]` set. Apply takes place on the next edge, `cnt[k]` is cleared, and `clk_out[k]` is unchanged.
- Loading `cfg_div=0` stops the channel at its next wrap. `clk_out` freezes at its current level.

## Timing
- Reset values:
  - `act = DEFAULT_DIV`
  - `shd = 0`
  - `pend = 0`
  - `cnt = 0`
  - `clk_out = 0`
  - `tick = 0`
  - `cfg_ready = 0` during rst, 1 on the first cycle after.
- Latency:
  - With `en[k]` high from the first edge after rst release, the first `tick[k]`/`clk_out[k]` toggle appears after `act[k]` enabled edges.
  - Period of `clk_out` is `2·act[k]` cycles.
- `act=1`: `clk_out` toggles every cycle (f_clk/2) and `tick` is held high continuously.
- Accept on the same edge as a wrap: the new value does not affect that wrap. It applies at the following wrap.
- While `pend[k]` is set, a second load to channel k stalls (`cfg_ready=0`). Loads to other channels are unaffected.
- `rst` mid-operation: all state returns to reset values on that edge, including in-flight pending loads.
- Channels never interact. Simultaneous wraps on all channels are legal and independent.

## Configuration
- CLKDIV_SYNC_EN defined:
  - Adds the `sync` input.
  - Edge with `sync=1` (and `rst=0`): every channel gets `cnt=0`, `clk_out=0`, `tick=0`. Any `pend` channel applies `act<=shd` and clears `pend`.
  - `rst` has priority over `sync`.
  - A config accept on the same edge as `sync` lands in `shd` and stays pending.
- CLKDIV_SYNC_EN undefined: no `sync` port and no realign logic. Channels align only through `rst`.

## Test plan
- Reset defaults: CHANNELS=2, CLK_FREQ=12, DEFAULT_HZ=1 (DEFAULT_DIV=6), `en=2'b11` -> both `clk_out` toggle every 6 cycles, first `tick` on the 6th edge after rst low, period 12.
- Shadow load: on ch0 (act=6), load `cfg_div=3` at `cnt=2` -> current half-period finishes at 6, then toggles every 3. `cfg_ready` is low for ch0 until the apply edge and high for ch1 throughout.
- Edge cases:
  - `cfg_div=1` -> `tick[0]` constantly high and `clk_out[0]` toggles every cycle.
  - `cfg_div=0` -> channel freezes after the next wrap with `tick=0`.
  - Reload 4 while stopped -> applies on the next edge and runs from `cnt=0`.
- Enable gating: drop `en[1]` for 5 cycles mid-count at `cnt=3` -> counter holds at 3. Resuming delays the next toggle by exactly 5 cycles. A load while disabled applies in 1 cycle.
- Mid-operation reset: assert rst for 1 cycle while `pend[0]=1` and `clk_out=1` -> all outputs 0, `pend` cleared, `act=DEFAULT_DIV`.
- With CLKDIV_SYNC_EN: channels at divisors 3 and 5, pulse `sync` -> both `clk_out=0` and `cnt=0`, and the first toggles follow at 3 and 5 cycles respectively.

Source files
------------

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: CHANNELS runtime-programmable 50% duty clock dividers with tick strobes.
// Defining CLKDIV_SYNC_EN adds a sync input that realigns every channel at once.
module clock_divider_multi #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 24,
    parameter int CLK_FREQ    = 12_000_000,
    parameter int DEFAULT_HZ  = 1,
    parameter int DEFAULT_DIV = CLK_FREQ / (2 * DEFAULT_HZ),
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic                sync
`endif
);
    localparam int PW = 2 ** CW;
    logic [CHANNELS-1:0] pend;
    logic [PW-1:0]       pend_x;
    logic                accept;
    // Channel indices past CHANNELS read as never pending, so they are accepted and dropped.
    assign pend_x    = PW'(pend);
    assign cfg_ready = ~pend_x[cfg_chan] & ~rst;
    assign accept    = cfg_valid & cfg_ready;
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DIV_W-1:0] act_q, act_d, shd_q, shd_d, cnt_q, cnt_d;
        logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, run, wrap;
        assign run  = en[k] & (act_q != '0);
        assign wrap = run & (cnt_q == act_q - DIV_W'(1));
        always_comb begin
            act_d  = act_q;
            shd_d  = shd_q;
            pend_d = pend_q;
            cnt_d  = run ? (wrap ? '0 : cnt_q + DIV_W'(1)) : cnt_q;
            clk_d  = clk_q ^ wrap;
            tick_d = wrap;
            // A pending divisor lands on a half-period boundary or whenever the channel is idle.
            if (pend_q & (wrap | ~run)) begin
                act_d  = shd_q;
                pend_d = 1'b0;
                cnt_d  = '0;
            end
`ifdef CLKDIV_SYNC_EN
            if (sync) begin
                cnt_d  = '0;
                clk_d  = 1'b0;
                tick_d = 1'b0;
                if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
            end
`endif
            if (accept && cfg_chan == CW'(k)) begin
                shd_d  = cfg_div;
                pend_d = 1'b1;
            end
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                act_q  <= DIV_W'(DEFAULT_DIV);
                shd_q  <= '0;
                pend_q <= 1'b0;
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                act_q  <= act_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                cnt_q  <= cnt_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end
        assign pend[k]    = pend_q;
        assign clk_out[k] = clk_q;
        assign tick[k]    = tick_q;
    end
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed checks of clock_divider_multi with three channels and DEFAULT_DIV=6.
// Sync realign checks are included when CLKDIV_SYNC_EN is defined.
module tb_clock_divider_multi;
    localparam int CH = 3;
    localparam int DW = 8;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] en = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_chan = '0;
    logic [DW-1:0] cfg_div = '0;
    logic [CH-1:0] clk_out, tick;
    logic [CH-1:0] e_tick, e_clk;
    logic          e_t0, e_t2, e_c0, e_c2;
`ifdef CLKDIV_SYNC_EN
    logic          sync = 1'b0;
`endif
    int n = 0;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    clock_divider_multi #(
        .CHANNELS(CH), .DIV_W(DW), .CLK_FREQ(12), .DEFAULT_HZ(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick)
`ifdef CLKDIV_SYNC_EN
        , .sync(sync)
`endif
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
        n++;
    endtask
    initial begin
        step;
        step;
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_ready", cfg_ready, 0);
        rst = 1'b0;
        en  = '1;
        n   = 0;
        #1;
        check("ready_after_rst", cfg_ready, 1);
        // Default divisor 6: tick every 6th edge, period 12.
        for (int i = 1; i <= 12; i++) begin
            step;
            check("def_tick", tick, (n % 6 == 0) ? 3'b111 : 3'b000);
            check("def_clk", clk_out, ((n / 6) % 2 == 1) ? 3'b111 : 3'b000);
        end
        // Shadow load of 3 into ch0 while its counter is at 2.
        step;
        step;
        cfg_chan  = 2'd0;
        cfg_div   = 8'd3;
        cfg_valid = 1'b1;
        #1;
        check("load_ready", cfg_ready, 1);
        step;
        cfg_valid = 1'b0;
        check("pend_ready0", cfg_ready, 0);
        e_clk = '0;
        for (int i = 16; i <= 27; i++) begin
            step;
            e_tick[0]   = (n >= 18) && (n % 3 == 0);
            e_tick[2:1] = {2{n % 6 == 0}};
            e_clk       = e_clk ^ e_tick;
            check("shadow_tick", tick, e_tick);
            check("shadow_clk", clk_out, e_clk);
            cfg_chan = 2'd0;
            #1;
            check("shadow_ready0", cfg_ready, n >= 18);
            cfg_chan = 2'd1;
            #1;
            check("shadow_ready1", cfg_ready, 1);
        end
        // Divisor 1: tick held high, clk_out toggles every edge.
        cfg_chan  = 2'd0;
        cfg_div   = 8'd1;
        cfg_valid = 1'b1;
        e_c0      = 1'b0;
        for (int i = 28; i <= 34; i++) begin
            step;
            cfg_valid = 1'b0;
            e_t0 = (n >= 30);
            e_c0 = e_c0 ^ e_t0;
            check("div1_tick", tick[0], e_t0);
            check("div1_clk", clk_out[0], e_c0);
        end
        // Divisor 0: accepted on a wrap, applied on the next wrap, then frozen.
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        for (int i = 35; i <= 40; i++) begin
            step;
            cfg_valid = 1'b0;
            e_t0 = (n <= 36);
            e_c0 = e_c0 ^ e_t0;
            check("stop_tick", tick[0], e_t0);
            check("stop_clk", clk_out[0], e_c0);
        end
        // Reload 4 while stopped: applies on the following edge, runs from cnt=0.
        cfg_div   = 8'd4;
        cfg_valid = 1'b1;
        for (int i = 41; i <= 46; i++) begin
            step;
            cfg_valid = 1'b0;
            e_t0 = (n == 46);
            e_c0 = e_c0 ^ e_t0;
            check("reload_tick", tick[0], e_t0);
            check("reload_clk", clk_out[0], e_c0);
            check("reload_ready", cfg_ready, n >= 42);
        end
        // Gate ch1 for 5 edges with its counter at 3: toggle moves from 54 to 59.
        for (int i = 47; i <= 51; i++) step;
        en = 3'b101;
        for (int i = 52; i <= 60; i++) begin
            step;
            if (n == 56) en = '1;
            check("gate_tick1", tick[1], n == 59);
            check("gate_clk1", clk_out[1], n >= 59);
        end
        // Load 2 into ch2 while disabled: applies one edge later.
        en        = 3'b011;
        cfg_chan  = 2'd2;
        cfg_div   = 8'd2;
        cfg_valid = 1'b1;
        e_c2      = 1'b0;
        for (int i = 61; i <= 66; i++) begin
            step;
            cfg_valid = 1'b0;
            if (n == 62) en = '1;
            e_t2 = (n == 64) || (n == 66);
            e_c2 = e_c2 ^ e_t2;
            check("idle_tick2", tick[2], e_t2);
            check("idle_clk2", clk_out[2], e_c2);
            check("idle_ready2", cfg_ready, n >= 62);
        end
        // Out-of-range channel: accepted and discarded.
        cfg_chan  = 2'd3;
        cfg_div   = 8'd1;
        cfg_valid = 1'b1;
        #1;
        check("oor_ready", cfg_ready, 1);
        step;
        cfg_valid = 1'b0;
        for (int c = 0; c < CH; c++) begin
            cfg_chan = 2'(c);
            #1;
            check("oor_no_pend", cfg_ready, 1);
        end
        // Reset while ch0 is pending with clk_out high.
        check("pre_rst_clk0", clk_out[0], 1);
        cfg_chan  = 2'd0;
        cfg_div   = 8'd5;
        cfg_valid = 1'b1;
        step;
        cfg_valid = 1'b0;
        check("pre_rst_pend", cfg_ready, 0);
        rst = 1'b1;
        step;
        check("mid_rst_clk", clk_out, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_ready", cfg_ready, 0);
        rst = 1'b0;
        en  = '1;
        #1;
        check("post_rst_ready", cfg_ready, 1);
        for (int i = 70; i <= 75; i++) begin
            step;
            check("post_rst_tick", tick, (n == 75) ? 3'b111 : 3'b000);
            check("post_rst_clk", clk_out, (n == 75) ? 3'b111 : 3'b000);
        end
`ifdef CLKDIV_SYNC_EN
        // Divisors 3 and 5 on ch0/ch1, then realign with sync.
        cfg_chan  = 2'd0;
        cfg_div   = 8'd3;
        cfg_valid = 1'b1;
        step;
        cfg_chan = 2'd1;
        cfg_div  = 8'd5;
        step;
        cfg_valid = 1'b0;
        for (int i = 78; i <= 83; i++) step;
        sync = 1'b1;
        step;
        sync = 1'b0;
        check("sync_clk", clk_out, 0);
        check("sync_tick", tick, 0);
        for (int i = 85; i <= 90; i++) begin
            step;
            check("sync_tick0", tick[0], (n == 87) || (n == 90));
            check("sync_tick1", tick[1], n == 89);
            check("sync_clk0", clk_out[0], (n >= 87) && (n < 90));
            check("sync_clk1", clk_out[1], n >= 89);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
